// File: rtl/program_counter_unit.sv
// Program counter with branch/jump/ROM-bank selection, input-wait handshake and halt.
// Optional macro CONFIRM_DEBOUNCE_EN adds a level debouncer on the synchronised confirm button.
module program_counter_unit #(
  parameter int ADDR_W          = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        Jump,
  input  logic              Branch,
  input  logic              zero,
  input  logic              halt,
  input  logic              input_flag,
  input  logic              confirm,
  input  logic [15:0]       imm,
  input  logic [25:0]       jump_target,
  input  logic [31:0]       reg_value,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              stall,
  output logic              input_ready,
  output logic              halted,
  output logic [1:0]        rom_sel
);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT_IN = 2'd1, HALTED = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        rom_sel_q, rom_sel_d;
  logic [1:0]        sync_q;
  logic              level_prev_q;
  logic              edge_q;
  logic              conf_level;
  logic [ADDR_W-1:0] br_target;

  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign br_target = ADDR_W'(32'(pc_plus1) + {{16{imm[15]}}, imm});
  assign pc        = pc_q;
  assign rom_sel   = rom_sel_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], confirm};
    end
  end

`ifdef CONFIRM_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_level_q, deb_level_d;

  // Count consecutive cycles the synchronised input disagrees with the accepted level.
  always_comb begin
    deb_cnt_d   = '0;
    deb_level_d = deb_level_q;
    if (sync_q[1] != deb_level_q) begin
      if (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_level_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
    end
  end

  assign conf_level = deb_level_q;
`else
  logic unused_param;
  assign unused_param = (DEBOUNCE_CYCLES > 0);
  assign conf_level   = sync_q[1];
`endif

  // Registered rising-edge pulse; a level already high when WAIT_IN starts produces no pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_prev_q <= 1'b0;
      edge_q       <= 1'b0;
    end else begin
      level_prev_q <= conf_level;
      edge_q       <= conf_level & ~level_prev_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      pc_q      <= '0;
      rom_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rom_sel_q <= rom_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    rom_sel_d = rom_sel_q;
    case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (input_flag) begin
          state_d = WAIT_IN;
        end else begin
          case (Jump)
            2'b11: begin
              pc_d      = '0;
              rom_sel_d = reg_value[1:0];
            end
            2'b10:   pc_d = ADDR_W'(reg_value);
            2'b01:   pc_d = ADDR_W'(jump_target);
            default: pc_d = (Branch && zero) ? br_target : pc_plus1;
          endcase
        end
      end
      WAIT_IN: begin
        if (edge_q) begin
          state_d = RUN;
          pc_d    = pc_plus1;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    halted      = 1'b0;
    input_ready = 1'b0;
    case (state_q)
      WAIT_IN: begin
        stall       = 1'b1;
        input_ready = edge_q;
      end
      HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
